// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler: shares one TotalALU between two requesters.
// Requests are granted on a valid/ready handshake with round-robin
// arbitration. The grant is taken only while IDLE. The block drives the ALU
// Signal/dataA/dataB inputs and times single-cycle and DIVU operations. After
// a DIVU it issues MFHI and then MFLO, and returns the Hi/Lo pair in a single
// response.
// Optional build macro: SCHED_PERF_CNT_EN. When it is defined, the block adds
// the perf_ops and perf_div_cycles counters.
module alu_op_scheduler #(
  parameter int unsigned SINGLE_LAT = 1,
  parameter int unsigned DIV_LAT    = 33,
  parameter logic [5:0]  IDLE_FUNCT = 6'd32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [5:0]  req0_funct,
  input  logic [5:0]  req1_funct,
  input  logic [31:0] req0_a,
  input  logic [31:0] req1_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic        rsp_err,
  output logic [31:0] rsp_lo,
  output logic [31:0] rsp_hi,
  output logic        busy,
  output logic [5:0]  alu_signal,
  output logic [31:0] alu_data_a,
  output logic [31:0] alu_data_b,
  input  logic [31:0] alu_output
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0] perf_ops,
  output logic [31:0] perf_div_cycles
`endif
);

  // FSM encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_EXEC = 3'd1;
  localparam logic [2:0] ST_MFHI = 3'd2;
  localparam logic [2:0] ST_MFLO = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  // ALU funct codes
  localparam logic [5:0] F_SLL  = 6'd0;
  localparam logic [5:0] F_SRL  = 6'd2;
  localparam logic [5:0] F_ADD  = 6'd32;
  localparam logic [5:0] F_SUB  = 6'd34;
  localparam logic [5:0] F_AND  = 6'd36;
  localparam logic [5:0] F_OR   = 6'd37;
  localparam logic [5:0] F_SLT  = 6'd42;
  localparam logic [5:0] F_DIVU = 6'd27;
  localparam logic [5:0] F_MFHI = 6'd16;
  localparam logic [5:0] F_MFLO = 6'd18;

  // The counter must be able to hold the longer of the two latencies.
  localparam int unsigned CNT_MAX = (DIV_LAT > SINGLE_LAT) ? DIV_LAT : SINGLE_LAT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_SINGLE = CNT_W'(SINGLE_LAT);
  localparam logic [CNT_W-1:0] CNT_DIV    = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

  // Returns 1 for a funct code that the ALU executes through this scheduler.
  function automatic logic is_supported(input logic [5:0] funct);
    logic ok;
    case (funct)
      F_SLL, F_SRL, F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_DIVU: ok = 1'b1;
      default:                                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Returns the EXEC counter load value for a funct code.
  function automatic logic [CNT_W-1:0] exec_load(input logic [5:0] funct);
    logic [CNT_W-1:0] load;
    if (funct == F_DIVU) begin
      load = CNT_DIV;
    end else begin
      load = CNT_SINGLE;
    end
    return load;
  endfunction

  // State and latched request
  logic [2:0]       state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [5:0]       funct_q,      funct_d;
  logic [31:0]      op_a_q,       op_a_d;
  logic [31:0]      op_b_q,       op_b_d;
  logic             id_q,         id_d;
  logic             last_grant_q, last_grant_d;
  logic [31:0]      hi_res_q,     hi_res_d;

  // Registered outputs
  logic             rsp_valid_q,  rsp_valid_d;
  logic             rsp_id_q,     rsp_id_d;
  logic             rsp_err_q,    rsp_err_d;
  logic [31:0]      rsp_lo_q,     rsp_lo_d;
  logic [31:0]      rsp_hi_q,     rsp_hi_d;
  logic             busy_q,       busy_d;
  logic [5:0]       alu_signal_q, alu_signal_d;
  logic [31:0]      alu_a_q,      alu_a_d;
  logic [31:0]      alu_b_q,      alu_b_d;

  // Arbitration result
  logic             grant_valid_s;
  logic             grant_id_s;
  logic [5:0]       sel_funct_s;
  logic [31:0]      sel_a_s;
  logic [31:0]      sel_b_s;

  // Round-robin arbitration. Only IDLE grants, and nothing is granted during reset.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    if ((state_q == ST_IDLE) && !reset) begin
      case (req_valid)
        2'b01: begin
          grant_valid_s = 1'b1;
          grant_id_s    = 1'b0;
        end
        2'b10: begin
          grant_valid_s = 1'b1;
          grant_id_s    = 1'b1;
        end
        2'b11: begin
          grant_valid_s = 1'b1;
          grant_id_s    = ~last_grant_q;
        end
        default: begin
          grant_valid_s = 1'b0;
          grant_id_s    = 1'b0;
        end
      endcase
    end else begin
      grant_valid_s = 1'b0;
      grant_id_s    = 1'b0;
    end
  end

  // Ready strobe and operand mux for the granted requester
  always_comb begin
    req_ready = 2'b00;
    if (grant_valid_s) begin
      if (grant_id_s) begin
        req_ready = 2'b10;
      end else begin
        req_ready = 2'b01;
      end
    end else begin
      req_ready = 2'b00;
    end
    if (grant_id_s) begin
      sel_funct_s = req1_funct;
      sel_a_s     = req1_a;
      sel_b_s     = req1_b;
    end else begin
      sel_funct_s = req0_funct;
      sel_a_s     = req0_a;
      sel_b_s     = req0_b;
    end
  end

  // FSM next state, operation sequencing and result capture
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    funct_d      = funct_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    hi_res_d     = hi_res_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    rsp_lo_d     = rsp_lo_q;
    rsp_hi_d     = rsp_hi_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid_s) begin
          funct_d      = sel_funct_s;
          op_a_d       = sel_a_s;
          op_b_d       = sel_b_s;
          id_d         = grant_id_s;
          last_grant_d = grant_id_s;
          if (is_supported(sel_funct_s)) begin
            state_d = ST_EXEC;
            cnt_d   = exec_load(sel_funct_s);
          end else begin
            // Unsupported funct: respond at once with an error and leave the ALU idle.
            state_d   = ST_RESP;
            cnt_d     = CNT_ZERO;
            rsp_id_d  = grant_id_s;
            rsp_err_d = 1'b1;
            rsp_lo_d  = 32'd0;
            rsp_hi_d  = 32'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cnt_q == CNT_ONE) begin
          if (funct_q == F_DIVU) begin
            // Hi/Lo are now valid inside the ALU. Read them back.
            state_d = ST_MFHI;
            cnt_d   = CNT_SINGLE;
          end else begin
            state_d   = ST_RESP;
            cnt_d     = CNT_ZERO;
            rsp_id_d  = id_q;
            rsp_err_d = 1'b0;
            rsp_lo_d  = alu_output;
            rsp_hi_d  = 32'd0;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_MFHI: begin
        if (cnt_q == CNT_ONE) begin
          hi_res_d = alu_output;
          state_d  = ST_MFLO;
          cnt_d    = CNT_SINGLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_MFLO: begin
        if (cnt_q == CNT_ONE) begin
          state_d   = ST_RESP;
          cnt_d     = CNT_ZERO;
          rsp_id_d  = id_q;
          rsp_err_d = 1'b0;
          rsp_lo_d  = alu_output;
          rsp_hi_d  = hi_res_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Output values for the next cycle, derived from the next state
  always_comb begin
    busy_d       = (state_d != ST_IDLE);
    rsp_valid_d  = (state_d == ST_RESP);
    alu_signal_d = IDLE_FUNCT;
    alu_a_d      = 32'd0;
    alu_b_d      = 32'd0;
    case (state_d)
      ST_EXEC: begin
        alu_signal_d = funct_d;
        alu_a_d      = op_a_d;
        alu_b_d      = op_b_d;
      end
      ST_MFHI: begin
        alu_signal_d = F_MFHI;
        alu_a_d      = op_a_d;
        alu_b_d      = op_b_d;
      end
      ST_MFLO: begin
        alu_signal_d = F_MFLO;
        alu_a_d      = op_a_d;
        alu_b_d      = op_b_d;
      end
      default: begin
        alu_signal_d = IDLE_FUNCT;
        alu_a_d      = 32'd0;
        alu_b_d      = 32'd0;
      end
    endcase
  end

  // State and output registers. Reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      funct_q      <= 6'd0;
      op_a_q       <= 32'd0;
      op_b_q       <= 32'd0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      hi_res_q     <= 32'd0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_lo_q     <= 32'd0;
      rsp_hi_q     <= 32'd0;
      busy_q       <= 1'b0;
      alu_signal_q <= IDLE_FUNCT;
      alu_a_q      <= 32'd0;
      alu_b_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      funct_q      <= funct_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      hi_res_q     <= hi_res_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      rsp_lo_q     <= rsp_lo_d;
      rsp_hi_q     <= rsp_hi_d;
      busy_q       <= busy_d;
      alu_signal_q <= alu_signal_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_lo     = rsp_lo_q;
  assign rsp_hi     = rsp_hi_q;
  assign busy       = busy_q;
  assign alu_signal = alu_signal_q;
  assign alu_data_a = alu_a_q;
  assign alu_data_b = alu_b_q;

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] perf_ops_q;
  logic [31:0] perf_div_q;
  logic        div_cycle_s;

  // A DIVU cycle is any cycle in EXEC, MFHI or MFLO that belongs to a DIVU.
  always_comb begin
    if ((funct_q == F_DIVU) &&
        ((state_q == ST_EXEC) || (state_q == ST_MFHI) || (state_q == ST_MFLO))) begin
      div_cycle_s = 1'b1;
    end else begin
      div_cycle_s = 1'b0;
    end
  end

  // Free-running performance counters. They wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_ops_q <= 32'd0;
      perf_div_q <= 32'd0;
    end else begin
      if (rsp_valid_q) begin
        perf_ops_q <= perf_ops_q + 32'd1;
      end
      if (div_cycle_s) begin
        perf_div_q <= perf_div_q + 32'd1;
      end
    end
  end

  assign perf_ops        = perf_ops_q;
  assign perf_div_cycles = perf_div_q;
`endif

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed testbench for alu_op_scheduler with a behavioural TotalALU stand-in.
// The DIVU model exposes Hi/Lo only after Signal has been held at DIVU for
// 33 consecutive cycles. Hi holds the remainder and Lo holds the quotient.
module tb_alu_op_scheduler;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [5:0]  req0_funct = 6'd0, req1_funct = 6'd0;
  logic [31:0] req0_a = 32'd0, req1_a = 32'd0, req0_b = 32'd0, req1_b = 32'd0;
  logic        rsp_valid, rsp_id, rsp_err, busy;
  logic [31:0] rsp_lo, rsp_hi;
  logic [5:0]  alu_signal;
  logic [31:0] alu_data_a, alu_data_b, alu_output;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0] perf_ops, perf_div_cycles;
`endif

  int vectors = 0;
  int miscompares = 0;

  alu_op_scheduler dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_funct(req0_funct), .req1_funct(req1_funct),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .busy(busy),
    .alu_signal(alu_signal), .alu_data_a(alu_data_a), .alu_data_b(alu_data_b),
    .alu_output(alu_output)
`ifdef SCHED_PERF_CNT_EN
    , .perf_ops(perf_ops), .perf_div_cycles(perf_div_cycles)
`endif
  );

  always #5 clk = ~clk;

  // TotalALU stand-in
  logic [31:0] m_hi, m_lo;
  int          div_run;

  function automatic logic [31:0] alu_fn(input logic [5:0] s, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
    case (s)
      6'd0:    return a << b[4:0];
      6'd2:    return a >> b[4:0];
      6'd32:   return a + b;
      6'd34:   return a - b;
      6'd36:   return a & b;
      6'd37:   return a | b;
      6'd42:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd16:   return hi;
      6'd18:   return lo;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_output = alu_fn(alu_signal, alu_data_a, alu_data_b, m_hi, m_lo);

  always @(posedge clk) begin
    if (reset) begin
      m_hi    <= 32'hDEAD_BEEF;
      m_lo    <= 32'hDEAD_BEEF;
      div_run <= 0;
    end else if (alu_signal == 6'd27) begin
      div_run <= div_run + 1;
      if (div_run == 32) begin
        m_hi <= (alu_data_b != 32'd0) ? alu_data_a % alu_data_b : 32'd0;
        m_lo <= (alu_data_b != 32'd0) ? alu_data_a / alu_data_b : 32'd0;
      end
    end else begin
      div_run <= 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req_valid = 2'b00;
    step();
    reset = 1'b0;
  endtask

  // Issues one request, waits for its grant, and then waits for the response.
  // lat is the number of cycles from the handshake to rsp_valid, or -1 on timeout.
  task automatic do_op(input logic id, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, output int lat);
    int w;
    if (id) begin
      req1_funct = f; req1_a = a; req1_b = b; req_valid = 2'b10;
    end else begin
      req0_funct = f; req0_a = a; req0_b = b; req_valid = 2'b01;
    end
    #1;
    w = 0;
    while (req_ready[id] !== 1'b1 && w < 50) begin
      step();
      w++;
    end
    if (w >= 50) begin
      req_valid = 2'b00;
      lat = -1;
    end else begin
      step();
      req_valid = 2'b00;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 100) begin
        step();
        lat++;
      end
      if (lat >= 100) lat = -1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 2'b00;
    step();
    step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b want 0", busy); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
    vectors++; if (alu_signal !== 6'd32) begin miscompares++; $display("FAIL reset_alu_signal: got %0d want 32", alu_signal); end
    vectors++; if (alu_data_a !== 32'd0 || alu_data_b !== 32'd0) begin miscompares++; $display("FAIL reset_alu_data: got %0h/%0h want 0/0", alu_data_a, alu_data_b); end
    vectors++; if (rsp_lo !== 32'd0 || rsp_hi !== 32'd0 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_rsp_fields: got lo=%0h hi=%0h id=%0b err=%0b want zeros", rsp_lo, rsp_hi, rsp_id, rsp_err);
    end
    req_valid = 2'b01;
    #1;
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_ready_gated: got %b want 00", req_ready); end
    req_valid = 2'b00;
    reset = 1'b0;
    step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle_after: got busy %0b want 0", busy); end
  endtask

  task automatic test_add();
    req0_funct = 6'd32; req0_a = 32'd5; req0_b = 32'd7; req_valid = 2'b01;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL add_ready: got %b want 01", req_ready); end
    step();
    req_valid = 2'b00;
    #1;
    vectors++; if (alu_signal !== 6'd32 || alu_data_a !== 32'd5 || alu_data_b !== 32'd7) begin
      miscompares++; $display("FAIL add_alu_drive: got sig=%0d a=%0d b=%0d want 32/5/7", alu_signal, alu_data_a, alu_data_b);
    end
    vectors++; if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 2'b00) begin
      miscompares++; $display("FAIL add_exec_flags: got busy=%0b rsp_valid=%0b ready=%b want 1/0/00", busy, rsp_valid, req_ready);
    end
    step();
    vectors++; if (rsp_valid !== 1'b1 || rsp_lo !== 32'd12 || rsp_id !== 1'b0 || rsp_hi !== 32'd0 || rsp_err !== 1'b0) begin
      miscompares++; $display("FAIL add_rsp: got v=%0b lo=%0d id=%0b hi=%0d err=%0b want 1/12/0/0/0", rsp_valid, rsp_lo, rsp_id, rsp_hi, rsp_err);
    end
    vectors++; if (alu_signal !== 6'd32 || alu_data_a !== 32'd0) begin
      miscompares++; $display("FAIL add_resp_idle_alu: got sig=%0d a=%0d want 32/0", alu_signal, alu_data_a);
    end
    step();
    vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_lo !== 32'd12) begin
      miscompares++; $display("FAIL add_after: got v=%0b busy=%0b lo=%0d want 0/0/12", rsp_valid, busy, rsp_lo);
    end
  endtask

  task automatic test_divu();
    int n27;
    int rsp_cycle;
    req1_funct = 6'd27; req1_a = 32'd100; req1_b = 32'd7; req_valid = 2'b10;
    #1;
    vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("FAIL divu_ready: got %b want 10", req_ready); end
    n27 = 0;
    rsp_cycle = -1;
    for (int k = 1; k <= 60; k++) begin
      step();
      req_valid = 2'b00;
      if (alu_signal == 6'd27) n27++;
      if (k == 34) begin
        vectors++; if (alu_signal !== 6'd16) begin miscompares++; $display("FAIL divu_mfhi_sig: got %0d want 16", alu_signal); end
      end
      if (k == 35) begin
        vectors++; if (alu_signal !== 6'd18) begin miscompares++; $display("FAIL divu_mflo_sig: got %0d want 18", alu_signal); end
      end
      if (rsp_valid === 1'b1) begin
        rsp_cycle = k;
        break;
      end
    end
    vectors++; if (n27 !== 33) begin miscompares++; $display("FAIL divu_hold_cycles: got %0d want 33", n27); end
    vectors++; if (rsp_cycle !== 36) begin miscompares++; $display("FAIL divu_latency: got %0d want 36", rsp_cycle); end
    vectors++; if (rsp_hi !== 32'd2 || rsp_lo !== 32'd14 || rsp_id !== 1'b1 || rsp_err !== 1'b0) begin
      miscompares++; $display("FAIL divu_rsp: got hi=%0d lo=%0d id=%0b err=%0b want 2/14/1/0", rsp_hi, rsp_lo, rsp_id, rsp_err);
    end
    step();
  endtask

  task automatic test_tie();
    apply_reset();
    req0_funct = 6'd34; req0_a = 32'd9; req0_b = 32'd4;
    req1_funct = 6'd37; req1_a = 32'd1; req1_b = 32'd2;
    req_valid = 2'b11;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL tie_first_grant: got %b want 01", req_ready); end
    step();
    req_valid = 2'b10;
    #1;
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL tie_busy_no_ready: got %b want 00", req_ready); end
    step();
    vectors++; if (rsp_valid !== 1'b1 || rsp_lo !== 32'd5 || rsp_id !== 1'b0) begin
      miscompares++; $display("FAIL tie_rsp0: got v=%0b lo=%0d id=%0b want 1/5/0", rsp_valid, rsp_lo, rsp_id);
    end
    step();
    vectors++; if (req_ready !== 2'b10) begin miscompares++; $display("FAIL tie_second_grant: got %b want 10", req_ready); end
    step();
    req_valid = 2'b00;
    step();
    vectors++; if (rsp_valid !== 1'b1 || rsp_lo !== 32'd3 || rsp_id !== 1'b1) begin
      miscompares++; $display("FAIL tie_rsp1: got v=%0b lo=%0d id=%0b want 1/3/1", rsp_valid, rsp_lo, rsp_id);
    end
    req_valid = 2'b11;
    step();
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL tie_third_grant: got %b want 01", req_ready); end
    step();
    req_valid = 2'b00;
    repeat (3) step();
  endtask

  task automatic test_unsupported();
    apply_reset();
    req0_funct = 6'd40; req0_a = 32'd3; req0_b = 32'd4; req_valid = 2'b01;
    #1;
    vectors++; if (req_ready !== 2'b01 || alu_signal !== 6'd32) begin
      miscompares++; $display("FAIL unsup_grant: got ready=%b sig=%0d want 01/32", req_ready, alu_signal);
    end
    step();
    req_valid = 2'b00;
    vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_lo !== 32'd0 || rsp_hi !== 32'd0) begin
      miscompares++; $display("FAIL unsup_rsp: got v=%0b err=%0b lo=%0h hi=%0h want 1/1/0/0", rsp_valid, rsp_err, rsp_lo, rsp_hi);
    end
    vectors++; if (alu_signal !== 6'd32 || alu_data_a !== 32'd0 || alu_data_b !== 32'd0) begin
      miscompares++; $display("FAIL unsup_alu_idle: got sig=%0d a=%0h b=%0h want 32/0/0", alu_signal, alu_data_a, alu_data_b);
    end
    step();
    vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_err !== 1'b1) begin
      miscompares++; $display("FAIL unsup_after: got v=%0b busy=%0b err=%0b want 0/0/1", rsp_valid, busy, rsp_err);
    end
  endtask

  task automatic test_back_to_back();
    logic        ids [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [5:0]  fns [4]  = '{6'd36, 6'd42, 6'd34, 6'd2};
    logic [31:0] as  [4]  = '{32'h0000_F0F0, 32'hFFFF_FFFF, 32'd3, 32'h80};
    logic [31:0] bs  [4]  = '{32'h0000_FF00, 32'd1, 32'd5, 32'd3};
    logic [31:0] exp [4]  = '{32'h0000_F000, 32'd1, 32'hFFFF_FFFE, 32'h10};
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(ids[i], fns[i], as[i], bs[i], lat);
      vectors++; if (lat !== 2) begin miscompares++; $display("FAIL b2b_latency[%0d]: got %0d want 2", i, lat); end
      vectors++; if (rsp_lo !== exp[i] || rsp_id !== ids[i]) begin
        miscompares++; $display("FAIL b2b_result[%0d]: got lo=%0h id=%0b want %0h/%0b", i, rsp_lo, rsp_id, exp[i], ids[i]);
      end
    end
    step();
  endtask

  task automatic test_reset_mid_div();
    int nrsp;
    int lat;
    apply_reset();
    req0_funct = 6'd27; req0_a = 32'd50; req0_b = 32'd3; req_valid = 2'b01;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL middiv_ready: got %b want 01", req_ready); end
    for (int k = 0; k < 10; k++) begin
      step();
      req_valid = 2'b00;
    end
    vectors++; if (alu_signal !== 6'd27) begin miscompares++; $display("FAIL middiv_exec_sig: got %0d want 27", alu_signal); end
    reset = 1'b1;
    step();
    vectors++; if (busy !== 1'b0 || alu_signal !== 6'd32 || rsp_valid !== 1'b0 || alu_data_a !== 32'd0) begin
      miscompares++; $display("FAIL middiv_abort: got busy=%0b sig=%0d v=%0b a=%0h want 0/32/0/0", busy, alu_signal, rsp_valid, alu_data_a);
    end
    reset = 1'b0;
    nrsp = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (rsp_valid === 1'b1) nrsp++;
    end
    vectors++; if (nrsp !== 0) begin miscompares++; $display("FAIL middiv_no_rsp: got %0d responses want 0", nrsp); end
    do_op(1'b0, 6'd32, 32'd1, 32'd1, lat);
    vectors++; if (lat !== 2 || rsp_lo !== 32'd2) begin
      miscompares++; $display("FAIL middiv_add_after: got lat=%0d lo=%0d want 2/2", lat, rsp_lo);
    end
    step();
  endtask

`ifdef SCHED_PERF_CNT_EN
  task automatic test_perf();
    int lat;
    apply_reset();
    do_op(1'b1, 6'd27, 32'd20, 32'd6, lat);
    vectors++; if (lat !== 36 || rsp_hi !== 32'd2 || rsp_lo !== 32'd3) begin
      miscompares++; $display("FAIL perf_divu: got lat=%0d hi=%0d lo=%0d want 36/2/3", lat, rsp_hi, rsp_lo);
    end
    do_op(1'b0, 6'd32, 32'd2, 32'd3, lat);
    do_op(1'b1, 6'd32, 32'd4, 32'd4, lat);
    step();
    vectors++; if (perf_ops !== 32'd3) begin miscompares++; $display("FAIL perf_ops: got %0d want 3", perf_ops); end
    vectors++; if (perf_div_cycles !== 32'd35) begin miscompares++; $display("FAIL perf_div_cycles: got %0d want 35", perf_div_cycles); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_divu();
    test_tie();
    test_unsupported();
    test_back_to_back();
    test_reset_mid_div();
`ifdef SCHED_PERF_CNT_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
